// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : gpu_pkg
//  Description : Shared types and constants for the rasterizer back end.
//                Holds the default screen size, the framebuffer writer FSM
//                encoding, memory-plane select codes, the packed pixel record
//                carried through the input FIFO, and the depth-test helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

    localparam int DEFAULT_SCREEN_W = 320;
    localparam int DEFAULT_SCREEN_H = 240;

    // Framebuffer writer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLIP = 3'd1,
        ST_RD_Z = 3'd2,
        ST_WR_C = 3'd3,
        ST_WR_Z = 3'd4
    } fsm_state_t;

    // Memory plane select
    localparam logic MEM_SEL_COLOR = 1'b0;
    localparam logic MEM_SEL_DEPTH = 1'b1;

    // One rasterizer output pixel as stored in the input FIFO
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  depth;
        logic [15:0] color;
    } pixel_t;

    localparam int PIXEL_W = $bits(pixel_t);

    // Depth test: the incoming pixel wins only when strictly nearer.
    // Equal depth keeps what is already in the framebuffer.
    function automatic logic depth_pass(input logic [1:0] new_depth,
                                        input logic [1:0] stored_depth);
        return new_depth < stored_depth;
    endfunction

    // Saturating 16-bit increment used by the status counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage : gpu_pkg
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_fifo
//  Description : Synchronous single-clock FIFO with full/empty flags.
//                Read data is presented combinationally from the head entry
//                (show-ahead), so a pop consumes the word visible this cycle.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clock    in   1      clock, all logic on posedge
//    reset_n  in   1      asynchronous active-low reset (pointers only)
//    wr_en    in   1      push request; ignored while full
//    wr_data  in   WIDTH  push data
//    rd_en    in   1      pop request; ignored while empty
//    rd_data  out  WIDTH  head entry
//    full     out  1      no free entry
//    empty    out  1      no valid entry
// ============================================================================
module pixel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    // One extra pointer bit distinguishes full from empty when the
    // index bits are equal.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_write;
    logic             do_read;

    assign do_write = wr_en && !full;
    assign do_read  = rd_en && !empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only observed behind valid pointers.
    always_ff @(posedge clock) begin
        if (do_write) begin
            storage[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = storage[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule : pixel_fifo
`default_nettype wire

// File: rtl/pixel_fb_writer.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_fb_writer
//  Description : Rasterizer back end. Buffers incoming pixels, clips them to
//                the screen, and performs a depth-tested read-modify-write
//                (read depth, write colour, write depth) against external
//                memory. Counts written and rejected pixels.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clock                in   1       clock, all logic on posedge
//    reset_n              in   1       asynchronous active-low reset
//    in_pixel_valid       in   1       pixel present this cycle
//    in_pixel_ready       out  1       FIFO can accept (= !full)
//    in_pixel_x/_y        in   16      pixel coordinates
//    in_pixel_depth       in   2       pixel depth, smaller = nearer
//    in_pixel_color       in   16      pixel colour
//    in_sig_clear_stats   in   1       synchronous clear of both counters
//    mem_req              out  1       request, held until mem_ack
//    mem_we               out  1       1 = write, 0 = read
//    mem_sel              out  1       0 = colour plane, 1 = depth plane
//    mem_addr             out  ADDR_W  word address y*SCREEN_W + x
//    mem_wdata            out  16      write data
//    mem_rdata            in   16      read data, valid with mem_ack
//    mem_ack              in   1       one-cycle completion pulse
//    out_busy             out  1       FIFO non-empty or FSM not idle
//    out_pixels_written   out  16      saturating count of written pixels
//    out_pixels_rejected  out  16      saturating count of clipped/occluded
// ============================================================================
module pixel_fb_writer
    import gpu_pkg::*;
#(
    parameter int SCREEN_W   = DEFAULT_SCREEN_W,
    parameter int SCREEN_H   = DEFAULT_SCREEN_H,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_pixel_valid,
    output logic              in_pixel_ready,
    input  logic [15:0]       in_pixel_x,
    input  logic [15:0]       in_pixel_y,
    input  logic [1:0]        in_pixel_depth,
    input  logic [15:0]       in_pixel_color,
    input  logic              in_sig_clear_stats,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              out_busy,
    output logic [15:0]       out_pixels_written,
    output logic [15:0]       out_pixels_rejected
);

    localparam logic [31:0] SCREEN_W_U = 32'(SCREEN_W);
    localparam logic [31:0] SCREEN_H_U = 32'(SCREEN_H);

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_pop;
    pixel_t fifo_in;
    pixel_t fifo_out;

    assign fifo_in = {in_pixel_x, in_pixel_y, in_pixel_depth, in_pixel_color};

    pixel_fifo #(
        .WIDTH (PIXEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (in_pixel_valid),
        .wr_data (fifo_in),
        .rd_en   (fifo_pop),
        .rd_data (fifo_out),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // No bypass: readiness depends on the current fill only.
    assign in_pixel_ready = !fifo_full;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    fsm_state_t        state,      state_n;
    pixel_t            px,         px_n;
    logic              req_q,      req_n;
    logic              we_q,       we_n;
    logic              sel_q,      sel_n;
    logic [ADDR_W-1:0] addr_q,     addr_n;
    logic [15:0]       wdata_q,    wdata_n;
    // Set on an ack that chains into another write: the request is raised
    // one cycle later so mem_req is low for the cycle after every ack.
    logic              launch_q,   launch_n;
    logic [15:0]       pixels_written;
    logic [15:0]       pixels_rejected;
    logic              inc_written;
    logic              inc_rejected;

    logic [31:0]       addr_full;
    logic              off_screen;
    logic              ack_seen;

    assign addr_full  = ({16'b0, px.y} * SCREEN_W_U) + {16'b0, px.x};
    // Compare in 32 bits so 16'hFFFF is clipped instead of wrapping.
    assign off_screen = ({16'b0, px.x} >= SCREEN_W_U) ||
                        ({16'b0, px.y} >= SCREEN_H_U);
    // Acks only count against an outstanding request.
    assign ack_seen   = req_q && mem_ack;

    always_comb begin
        state_n      = state;
        px_n         = px;
        req_n        = req_q;
        we_n         = we_q;
        sel_n        = sel_q;
        addr_n       = addr_q;
        wdata_n      = wdata_q;
        launch_n     = launch_q;
        fifo_pop     = 1'b0;
        inc_written  = 1'b0;
        inc_rejected = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    px_n     = fifo_out;
                    state_n  = ST_CLIP;
                end
            end

            ST_CLIP: begin
                if (off_screen) begin
                    inc_rejected = 1'b1;
                    state_n      = ST_IDLE;
                end else begin
                    req_n   = 1'b1;
                    we_n    = 1'b0;
                    sel_n   = MEM_SEL_DEPTH;
                    addr_n  = addr_full[ADDR_W-1:0];
                    state_n = ST_RD_Z;
                end
            end

            ST_RD_Z: begin
                if (ack_seen) begin
                    req_n = 1'b0;
                    if (depth_pass(px.depth, mem_rdata[1:0])) begin
                        we_n     = 1'b1;
                        sel_n    = MEM_SEL_COLOR;
                        wdata_n  = px.color;
                        launch_n = 1'b1;
                        state_n  = ST_WR_C;
                    end else begin
                        inc_rejected = 1'b1;
                        state_n      = ST_IDLE;
                    end
                end
            end

            ST_WR_C: begin
                if (launch_q) begin
                    req_n    = 1'b1;
                    launch_n = 1'b0;
                end else if (ack_seen) begin
                    req_n    = 1'b0;
                    sel_n    = MEM_SEL_DEPTH;
                    wdata_n  = {14'b0, px.depth};
                    launch_n = 1'b1;
                    state_n  = ST_WR_Z;
                end
            end

            ST_WR_Z: begin
                if (launch_q) begin
                    req_n    = 1'b1;
                    launch_n = 1'b0;
                end else if (ack_seen) begin
                    req_n       = 1'b0;
                    inc_written = 1'b1;
                    state_n     = ST_IDLE;
                end
            end

            default: begin
                req_n    = 1'b0;
                launch_n = 1'b0;
                state_n  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            px       <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            launch_q <= 1'b0;
        end else begin
            state    <= state_n;
            px       <= px_n;
            req_q    <= req_n;
            we_q     <= we_n;
            sel_q    <= sel_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            launch_q <= launch_n;
        end
    end

    // ------------------------------------------------------------------
    // Status counters; clear has priority over a same-cycle increment
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pixels_written  <= '0;
            pixels_rejected <= '0;
        end else if (in_sig_clear_stats) begin
            pixels_written  <= '0;
            pixels_rejected <= '0;
        end else begin
            if (inc_written) begin
                pixels_written <= sat_inc16(pixels_written);
            end
            if (inc_rejected) begin
                pixels_rejected <= sat_inc16(pixels_rejected);
            end
        end
    end

    assign mem_req             = req_q;
    assign mem_we              = we_q;
    assign mem_sel             = sel_q;
    assign mem_addr            = addr_q;
    assign mem_wdata           = wdata_q;
    assign out_busy            = !fifo_empty || (state != ST_IDLE);
    assign out_pixels_written  = pixels_written;
    assign out_pixels_rejected = pixels_rejected;

endmodule : pixel_fb_writer
`default_nettype wire
